pos_mul_serial: RTL and testbench
=================================

Name: pos_mul_serial

Overview:
- Sequential unsigned multiplier. Processes the right operand CHUNK bits per cycle.
- Each cycle, adds the partial product a*digit, left-shifted by digit_index*CHUNK, into a running accumulator. This is the same shifted-add operation as the combinational shifted adder; this block is its clocked consumer.
- Sits between operand producers and downstream Karatsuba recombination logic.
- valid/ready handshake on input and output.

Parameters:
- N_BITS_A, 8, width of left operand a.
- N_BITS_B, 8, width of right operand b; must be a multiple of CHUNK.
- CHUNK, 2, digit width of b consumed per cycle; 1 <= CHUNK <= N_BITS_B.
- Derived (localparam, not overridable): N_DIGITS = N_BITS_B/CHUNK; CNT_W = max(1, clog2(N_DIGITS)).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b valid
- in_ready  output  1  block can accept operands
- a  input  N_BITS_A  left operand, unsigned
- b  input  N_BITS_B  right operand, unsigned
- out_valid  output  1  product c valid
- out_ready  input  1  downstream accepts c
- c  output  N_BITS_A+N_BITS_B  product a*b, unsigned
- busy  output  1  high in RUN or DONE

Behaviour:
- One clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset (asynchronous, any state):
  - state=IDLE; accumulator, c, digit counter, latched operands = 0.
  - in_ready=1, out_valid=0, busy=0.
- States: IDLE, RUN, DONE.
- Outputs per state:
  - in_ready = (state==IDLE), combinational from state.
  - out_valid = (state==DONE).
  - busy = (state!=IDLE).
- IDLE:
  - On in_valid && in_ready at a rising edge: latch a and b, clear accumulator to 0, counter=0, go to RUN.
  - Without in_valid, hold state.
- RUN, one digit per edge:
  - digit = b_latched[counter*CHUNK +: CHUNK].
  - acc <= acc + ((a_latched*digit) << (counter*CHUNK)), computed at full width N_BITS_A+N_BITS_B.
  - The partial product is N_BITS_A+CHUNK bits before shifting; the final sum never exceeds the output width, so no carry is lost and no saturation is needed.
  - counter increments each edge.
  - On the edge processing digit N_DIGITS-1: c is loaded with the final sum, state goes to DONE, counter wraps to 0.
  - No early termination on zero digits; latency is fixed.
- Latency:
  - Operands accepted at edge E0; out_valid rises after edge E0+N_DIGITS.
  - CHUNK=N_BITS_B gives a single RUN cycle.
- DONE:
  - c and out_valid are held stable while out_ready=0, for any number of cycles.
  - On out_ready=1 at an edge: go to IDLE, out_valid drops. c keeps its last value (not cleared).
- No overlap:
  - A new operand pair is not accepted in the same edge as the output handshake; in_ready rises the cycle after.
  - Throughput is one product per N_DIGITS+2 cycles at best.
- in_valid while not in IDLE is ignored; a and b may change freely during RUN/DONE without affecting the result.
- out_ready in IDLE/RUN is ignored.
- rst_n asserted mid-RUN or in DONE aborts immediately to the reset values. No partial result is ever presented.
- Outputs are registered or decoded from state only; no combinational path from any input to any output.

Test Plan:
- Defaults (8x8, CHUNK=2): a=255, b=255, in_valid pulse, out_ready=1 -> out_valid rises exactly 4 cycles after accept edge, c=65025, in_ready back to 1 one cycle after output handshake.
- Zero operands: a=0, b=173, then a=201, b=0 -> c=0 both times, same 4-cycle latency, busy high exactly 5 cycles each.
- Backpressure: a=13, b=11, out_ready=0 for 6 cycles after out_valid -> c=143 stable, out_valid held; in_valid with a=7, b=9 during that window ignored; output retires on out_ready=1.
- Reset mid-operation: accept a=200, b=150, assert rst_n=0 asynchronously (between edges) after 2 RUN cycles -> c=0, out_valid=0, in_ready=1 immediately. Then a=3, b=5 -> c=15 after 4 cycles.
- Back-to-back: in_valid held high with a=100, b=100 then a=99, b=98, out_ready=1 -> c=10000 then c=9702; second accept occurs the cycle after the first output handshake.
- Parameter sweep (N_BITS_A=16, N_BITS_B=16, CHUNK in {1,4,16}): a=65535, b=65535 -> c=4294836225 with latency 16, 4, 1 cycles respectively.
- Random: 1000 random pairs against a reference model, with random out_ready stalls.

Source files
------------

// File: rtl/pos_mul_serial.sv
// Digit-serial unsigned multiplier: consumes CHUNK bits of b per cycle and
// accumulates shifted partial products a*digit, with valid/ready on both sides.
module pos_mul_serial #(
    parameter int N_BITS_A = 8,
    parameter int N_BITS_B = 8,
    parameter int CHUNK    = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_BITS_A-1:0]          a,
    input  logic [N_BITS_B-1:0]          b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N_BITS_A+N_BITS_B-1:0] c,
    output logic                         busy
);
    localparam int N_DIGITS = N_BITS_B / CHUNK;
    localparam int CNT_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int W        = N_BITS_A + N_BITS_B;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state, state_nx;
    logic [N_BITS_A-1:0] a_lat;
    logic [N_BITS_B-1:0] b_lat;
    logic [W-1:0]        acc, c_reg;
    logic [CNT_W-1:0]    cnt;

    logic [31:0]         sh;
    logic [CHUNK-1:0]    digit;
    logic [W-1:0]        pp, sum;
    logic                last, accept;

    // Current digit's partial product, aligned to its weight at full width.
    always_comb begin
        sh     = 32'(cnt) * 32'(CHUNK);
        digit  = CHUNK'(b_lat >> sh);
        pp     = W'(a_lat) * W'(digit);
        sum    = acc + (pp << sh);
        last   = (cnt == CNT_W'(N_DIGITS - 1));
        accept = in_valid && (state == IDLE);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)    state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_lat <= '0;
            b_lat <= '0;
            acc   <= '0;
            c_reg <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    a_lat <= a;
                    b_lat <= b;
                    acc   <= '0;
                    cnt   <= '0;
                end
                RUN: begin
                    acc <= sum;
                    if (last) begin
                        c_reg <= sum;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign c         = c_reg;
endmodule

// File: tb/tb_pos_mul_serial.sv
// Bench for pos_mul_serial: directed vector table, handshake corner cases,
// random pairs against a plain a*b model, and a 16x16 CHUNK sweep.
module tb_pos_mul_serial;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0]  a, b;
    logic [15:0] c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pos_mul_serial dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .busy(busy)
    );

    // 16x16 sweep instances sharing one stimulus
    logic [15:0]      s_a, s_b;
    logic             s_in_valid;
    logic             s_out_ready = 1'b1;
    logic [2:0]       s_in_ready, s_out_valid, s_busy;
    logic [2:0][31:0] s_c;

    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int CH = (g == 0) ? 1 : (g == 1) ? 4 : 16;
        pos_mul_serial #(.N_BITS_A(16), .N_BITS_B(16), .CHUNK(CH)) u_sw (
            .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready[g]),
            .a(s_a), .b(s_b), .out_valid(s_out_valid[g]), .out_ready(s_out_ready),
            .c(s_c[g]), .busy(s_busy[g])
        );
    end

    typedef struct {
        logic [7:0]  va;
        logic [7:0]  vb;
        logic [15:0] exp_c;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction from accept to output retirement. stall = cycles
    // out_ready is held low once out_valid is up; poke drives a competing
    // operand pair during that window.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tbv,
                          input logic [15:0] exp, input int stall, input bit poke,
                          input string tag);
        int lat, bcnt;
        a = ta; b = tbv; in_valid = 1'b1; out_ready = (stall == 0);
        check({tag, " in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        lat = 0; bcnt = 0;
        while (!out_valid && lat < 50) begin
            bcnt += int'(busy);
            tick();
            lat++;
        end
        bcnt += int'(busy);
        check({tag, " latency"}, lat, 4);
        check({tag, " c"}, c, exp);
        for (int s = 0; s < stall; s++) begin
            if (poke) begin in_valid = 1'b1; a = 8'd7; b = 8'd9; end
            tick();
            bcnt += int'(busy);
            check({tag, " held out_valid"}, out_valid, 1);
            check({tag, " held c"}, c, exp);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, " out_valid drop"}, out_valid, 0);
        check({tag, " in_ready back"}, in_ready, 1);
        check({tag, " c kept"}, c, exp);
        check({tag, " busy cycles"}, bcnt, 5 + stall);
    endtask

    initial begin
        vec_t vt[8];
        int   slat[3];
        int   k;
        logic [7:0]  ra, rb;
        logic [15:0] model_c;

        vt[0] = '{8'd255, 8'd255, 16'd65025};
        vt[1] = '{8'd0,   8'd173, 16'd0};
        vt[2] = '{8'd201, 8'd0,   16'd0};
        vt[3] = '{8'd1,   8'd1,   16'd1};
        vt[4] = '{8'd255, 8'd1,   16'd255};
        vt[5] = '{8'd1,   8'd255, 16'd255};
        vt[6] = '{8'd128, 8'd2,   16'd256};
        vt[7] = '{8'd170, 8'd85,  16'd14450};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        s_in_valid = 1'b0; s_a = '0; s_b = '0;
        #12;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset busy", busy, 0);
        check("reset c", c, 0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_op(vt[i].va, vt[i].vb, vt[i].exp_c, 0, 1'b0, $sformatf("vec%0d", i));

        // Backpressure with ignored operands during the stall
        run_op(8'd13, 8'd11, 16'd143, 6, 1'b1, "backpressure");
        tick();
        check("backpressure no accept", busy, 0);

        // Asynchronous reset after two RUN cycles
        a = 8'd200; b = 8'd150; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("pre-reset busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort c", c, 0);
        check("abort out_valid", out_valid, 0);
        check("abort in_ready", in_ready, 1);
        check("abort busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_op(8'd3, 8'd5, 16'd15, 0, 1'b0, "after reset");

        // Back-to-back with in_valid held high
        a = 8'd100; b = 8'd100; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        a = 8'd99; b = 8'd98;
        k = 0;
        while (!out_valid && k < 50) begin tick(); k++; end
        check("b2b first latency", k, 4);
        check("b2b first c", c, 10000);
        tick();
        check("b2b gap in_ready", in_ready, 1);
        check("b2b gap busy", busy, 0);
        tick();
        check("b2b second accepted", busy, 1);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 50) begin tick(); k++; end
        check("b2b second latency", k, 4);
        check("b2b second c", c, 9702);
        tick();

        // Random pairs with random stalls
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            model_c = 16'(ra) * 16'(rb);
            run_op(ra, rb, model_c, ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)),
                   1'($urandom_range(0, 1)), "random");
        end

        // Parameter sweep: 16x16 at CHUNK 1, 4, 16
        s_a = 16'hFFFF; s_b = 16'hFFFF; s_in_valid = 1'b1;
        for (int g = 0; g < 3; g++) check($sformatf("sweep%0d in_ready", g), s_in_ready[g], 1);
        tick();
        s_in_valid = 1'b0;
        slat = '{-1, -1, -1};
        for (int t = 0; t < 40; t++) begin
            for (int g = 0; g < 3; g++)
                if (s_out_valid[g] && slat[g] < 0) begin
                    slat[g] = t;
                    check($sformatf("sweep%0d c", g), s_c[g], 32'd4294836225);
                end
            tick();
        end
        check("sweep CHUNK1 latency", 64'(slat[0]), 16);
        check("sweep CHUNK4 latency", 64'(slat[1]), 4);
        check("sweep CHUNK16 latency", 64'(slat[2]), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
